// File: rtl/fetch_arb.sv
// Round-robin arbiter that shares one line-fetch/writeback engine between cache
// controllers. It latches the winner's command and holds one transaction in flight.
module fetch_arb #(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int num_req    = 2,
  localparam int TW = (list_depth > 1) ? $clog2(list_depth) : 1,
  localparam int IW = (num_req > 1) ? $clog2(num_req) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [num_req-1:0]            rq_req,
  input  logic [2*num_req-1:0]          rq_cmd,
  input  logic [TW*num_req-1:0]         rq_tag,
  input  logic [addr_width*num_req-1:0] rq_addr,
  input  logic [addr_width*num_req-1:0] rq_addr_pre,
  output logic [num_req-1:0]            rq_gnt,
  output logic [num_req-1:0]            rq_done,
  output logic                          eng_req,
  output logic [1:0]                    eng_cmd,
  output logic [TW-1:0]                 eng_tag,
  output logic [addr_width-1:0]         eng_addr,
  output logic [addr_width-1:0]         eng_addr_pre,
  input  logic                          eng_gnt,
  input  logic                          eng_done,
  output logic                          busy,
  output logic [IW-1:0]                 owner,
  output logic                          proto_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, NOP_DONE} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           last_q, last_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [TW-1:0]           tag_q, tag_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [addr_width-1:0]   addr_pre_q, addr_pre_d;
  logic                    proto_q, proto_d;

  logic                    any_req;
  logic [IW-1:0]           win;
  logic [1:0]              win_cmd;
  logic [TW-1:0]           win_tag;
  logic [addr_width-1:0]   win_addr;
  logic [addr_width-1:0]   win_addr_pre;

  // First requester set at or after last+1, wrapping; this gives round-robin fairness.
  always_comb begin
    any_req = 1'b0;
    win     = last_q;
    for (int k = 1; k <= num_req; k++) begin
      if (!any_req && rq_req[(int'(last_q) + k) % num_req]) begin
        any_req = 1'b1;
        win     = IW'((int'(last_q) + k) % num_req);
      end
    end
  end

  assign win_cmd      = rq_cmd[2*int'(win) +: 2];
  assign win_tag      = rq_tag[TW*int'(win) +: TW];
  assign win_addr     = rq_addr[addr_width*int'(win) +: addr_width];
  assign win_addr_pre = rq_addr_pre[addr_width*int'(win) +: addr_width];

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    tag_d      = tag_q;
    addr_d     = addr_q;
    addr_pre_d = addr_pre_q;
    proto_d    = proto_q;
    rq_gnt     = '0;
    rq_done    = '0;
    unique case (state_q)
      IDLE: begin
        if (eng_done) proto_d = 1'b1;
        if (any_req) begin
          rq_gnt[win] = 1'b1;
          owner_d     = win;
          last_d      = win;
          cmd_d       = win_cmd;
          tag_d       = win_tag;
          addr_d      = win_addr;
          addr_pre_d  = win_addr_pre;
          state_d     = (win_cmd == 2'b01 || win_cmd == 2'b10) ? ISSUE : NOP_DONE;
        end
      end
      ISSUE: begin
        // A completion before the engine has even accepted is bogus; flag it and keep the grant.
        if (eng_done) proto_d = 1'b1;
        if (eng_gnt)  state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (eng_done) begin
          rq_done[owner_q] = 1'b1;
          state_d          = IDLE;
        end
      end
      NOP_DONE: begin
        rq_done[owner_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments with an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= IW'(num_req - 1);
      owner_q    <= '0;
      cmd_q      <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
      addr_pre_q <= '0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      cmd_q      <= cmd_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      addr_pre_q <= addr_pre_d;
      proto_q    <= proto_d;
    end
  end

  assign eng_req      = (state_q == ISSUE);
  assign eng_cmd      = cmd_q;
  assign eng_tag      = tag_q;
  assign eng_addr     = addr_q;
  assign eng_addr_pre = addr_pre_q;
  assign busy         = (state_q != IDLE);
  assign owner        = owner_q;
  assign proto_err    = proto_q;

endmodule
